// File: rtl/rat_io_responder.sv
// rtl/rat_io_responder.sv - RAT CPU I/O bus port-side responder with interrupt generation
//
// Peripheral end of the RAT CPU I/O bus. CPU OUT writes land in byte-wide output
// registers. IN reads return the synchronized external inputs. Rising edges on the
// external inputs set pending interrupt bits, and a pulse FSM drives the CPU
// interrupt line from the masked pending set.
//
// Ports:
//   clk      in   1        clock
//   rst      in   1        synchronous active-high reset
//   port_id  in   8        CPU port address, valid every cycle
//   wr_data  in   8        CPU out_port data
//   io_strb  in   1        CPU write strobe (one write per high cycle)
//   rd_data  out  8        CPU in_port data, combinational from port_id and state
//   ext_in   in   8*N_IN   asynchronous external inputs, byte k = input port k
//   ext_out  out  8*N_OUT  output registers, byte k = output reg k
//   int_out  out  1        CPU interrupt request (registered)
//
// Register map:
//   IN_BASE+k   RO  synchronized ext_in byte k
//   OUT_BASE+k  RW  output register k
//   8'hF0       RW  interrupt mask (bit k enables source k)
//   8'hF1       RW  interrupt pending, write 1 to clear

module rat_io_responder #(
  parameter int         N_IN      = 4,
  parameter int         N_OUT     = 4,
  parameter logic [7:0] IN_BASE   = 8'h00,
  parameter logic [7:0] OUT_BASE  = 8'h40,
  parameter int         INT_PULSE = 2,
  parameter int         INT_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           port_id,
  input  logic [7:0]           wr_data,
  input  logic                 io_strb,
  output logic [7:0]           rd_data,
  input  logic [8*N_IN-1:0]    ext_in,
  output logic [8*N_OUT-1:0]   ext_out,
  output logic                 int_out
);

  localparam logic [7:0] MASK_ADDR = 8'hF0;
  localparam logic [7:0] PEND_ADDR = 8'hF1;

  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = IN_LO + N_IN - 1;
  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + N_OUT - 1;

  localparam int CNT_MAX = (INT_PULSE > INT_HOLD) ? INT_PULSE : INT_HOLD;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] PULSE_LOAD = CW'(INT_PULSE - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(INT_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Elaboration checks: parameter ranges and address map overlaps.
  generate
    if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
      $error("rat_io_responder: N_IN must be 1..8");
    end
    if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
      $error("rat_io_responder: N_OUT must be 1..16");
    end
    if (INT_PULSE < 1 || INT_HOLD < 1) begin : g_bad_timing
      $error("rat_io_responder: INT_PULSE and INT_HOLD must be >= 1");
    end
    if (IN_HI > 255 || OUT_HI > 255) begin : g_bad_range
      $error("rat_io_responder: port range exceeds 8-bit port_id space");
    end
    if (IN_LO <= OUT_HI && OUT_LO <= IN_HI) begin : g_overlap_io
      $error("rat_io_responder: input and output port ranges overlap");
    end
    if (IN_LO <= 241 && IN_HI >= 240) begin : g_overlap_in_ctl
      $error("rat_io_responder: input range overlaps F0/F1");
    end
    if (OUT_LO <= 241 && OUT_HI >= 240) begin : g_overlap_out_ctl
      $error("rat_io_responder: output range overlaps F0/F1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Input synchronizer plus a third stage for edge detection
  // ---------------------------------------------------------------------------
  logic [8*N_IN-1:0] sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ext_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Edges are ignored until the synchronizer has been refilled from real inputs;
  // otherwise inputs already high through reset would look like rising edges.
  logic [1:0] prime_cnt;
  logic       primed;

  assign primed = (prime_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt <= 2'd0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  logic [N_IN-1:0] src_edge;

  always_comb begin
    src_edge = '0;
    for (int k = 0; k < N_IN; k++) begin
      src_edge[k] = primed && (|(sync2[8*k +: 8] & ~sync3[8*k +: 8]));
    end
  end

  // ---------------------------------------------------------------------------
  // Mask / pending registers
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] int_mask, int_pend, pend_clr;
  logic            mask_wr, pend_wr;

  assign mask_wr  = io_strb && (port_id == MASK_ADDR);
  assign pend_wr  = io_strb && (port_id == PEND_ADDR);
  assign pend_clr = pend_wr ? wr_data[N_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_mask <= '0;
      int_pend <= '0;
    end else begin
      if (mask_wr) begin
        int_mask <= wr_data[N_IN-1:0];
      end
      // New edge applied after the clear so a same-cycle edge keeps the bit set.
      int_pend <= (int_pend & ~pend_clr) | src_edge;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [7:0] out_reg [N_OUT];

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      if (rst) begin
        out_reg[k] <= 8'h00;
      end else if (io_strb && (port_id == OUT_BASE + 8'(k))) begin
        out_reg[k] <= wr_data;
      end
    end
  end

  always_comb begin
    ext_out = '0;
    for (int k = 0; k < N_OUT; k++) begin
      ext_out[8*k +: 8] = out_reg[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: pure decode, no side effects, since port_id is not qualified.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < N_IN; k++) begin
      if (port_id == IN_BASE + 8'(k)) begin
        rd_data = sync2[8*k +: 8];
      end
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (port_id == OUT_BASE + 8'(k)) begin
        rd_data = out_reg[k];
      end
    end
    if (port_id == MASK_ADDR) begin
      rd_data = 8'(int_mask);
    end
    if (port_id == PEND_ADDR) begin
      rd_data = 8'(int_pend);
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt pulse FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } int_state_t;

  int_state_t      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            int_req, int_nxt;

  assign int_req = |(int_pend & int_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      int_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      int_out <= int_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (int_req) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ST_ASSERT: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        // A request still present at the end of the dead time re-fires
        // immediately, so the line is low for exactly INT_HOLD cycles.
        if (cnt == '0) begin
          if (int_req) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = PULSE_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    int_nxt = (state_nxt == ST_ASSERT);
  end

endmodule
